ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Receives PS/2 keyboard frames and decodes set-2 scancodes, including E0/F0 prefixes.
//  Sits directly upstream of the game datapath and drives its keycode, key_make and key_ext inputs.
//  Outputs are registered and hold their last decoded key; key_valid marks each new key event.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000  clk cycles with no PS/2 clock fall mid-frame before abort (1 ms @ 50 MHz)
//  FILTER_LEN      8       consecutive equal synced samples required to change filtered ps2_clk
//  SYNC_STAGES     2       flip-flop synchronizer depth on ps2_clk and ps2_dat (>=2)
// PORTS
//  clk        in   1  system clock, 50 MHz
//  resetn     in   1  asynchronous, active-low reset
//  ps2_clk    in   1  raw PS/2 clock from keyboard, asynchronous
//  ps2_dat    in   1  raw PS/2 data from keyboard, asynchronous
//  keycode    out  8  last emitted scancode byte, prefixes stripped
//  key_make   out  1  1 = last event was a press, 0 = a release (F0 seen)
//  key_ext    out  1  1 = last event carried the E0 prefix
//  key_valid  out  1  one-clk pulse; keycode, key_make and key_ext update in this same cycle
//  frame_err  out  1  one-clk pulse on parity, start, stop or timeout error
// BEHAVIOUR
//  Reset state:
//   - keycode=0, key_make=0, key_ext=0, key_valid=0, frame_err=0
//   - ext_pend=0, brk_pend=0, FSM=IDLE, filtered clock=1, synchronizers=1
//  Input conditioning:
//   - Both PS/2 inputs pass through SYNC_STAGES flip-flops.
//   - Filtered clock takes the synced value only after FILTER_LEN identical consecutive samples.
//   - A "fall" is a 1->0 transition of the filtered clock; data is sampled on that same clk.
//  Frame FSM (advances only on a fall):
//   - IDLE: dat=0 -> DATA with bitcnt=0; dat=1 -> stay in IDLE, raise frame_err.
//   - DATA: shift in LSB first; after the 8th bit -> PARITY.
//   - PARITY: check odd parity over data+parity bit; latch the result -> STOP.
//   - STOP: dat=1 and parity ok -> byte done; otherwise frame_err. Always -> IDLE.
//  Timeout:
//   - In any state other than IDLE, a counter increments each clk and clears on each fall.
//   - On reaching TIMEOUT_CYCLES: -> IDLE, frame_err pulse, ext_pend=0, brk_pend=0.
//  Any frame error also clears ext_pend and brk_pend; outputs keep their old values.
//  Byte handling (byte done on a fall at cycle N; effects at cycle N+1):
//   - E0 -> ext_pend=1; F0 -> brk_pend=1; E1 -> ignored (pending flags unchanged). No key_valid.
//   - Any other byte:
//     - keycode=byte, key_ext=ext_pend, key_make=~brk_pend, key_valid=1
//     - then ext_pend=0, brk_pend=0
//  Back-to-back bytes are processed independently; no lower bound on inter-frame gap.
//  key_valid and frame_err can never assert in the same cycle.
//  Latency from raw ps2_clk fall on the stop bit to key_valid <= SYNC_STAGES+FILTER_LEN+2 clk.
//  resetn asserted mid-frame:
//   - Immediately returns everything to reset state; the partial frame is lost.
//   - The resulting misaligned frame is recovered by a stop/parity error or by the timeout.
//  Transmit to the keyboard (host-to-device) is not supported; ps2_clk/ps2_dat are input-only.
// CONFIGURATION
//  PS2_TYPEMATIC_FILTER_EN defined:
//   - Stores the last make {ext,code}.
//   - A make whose {ext,code} equals the stored value, with no intervening break of that key,
//     is suppressed: no key_valid, outputs unchanged.
//   - A break of that key, an error, or reset clears the stored value.
//  Not defined: every make, including typematic repeats, emits key_valid.
// TESTING
//  1. Frames E0,75 -> one key_valid; keycode=75, key_ext=1, key_make=1; frame_err never high.
//  2. Frames E0,F0,75 then 1C -> key_valid #1: 75/ext1/make0; key_valid #2: 1C/ext0/make1.
//  3. Frame 1C with parity=1 (bad) -> one frame_err, no key_valid, outputs hold; next good 29 decodes.
//  4. Five data bits, then idle TIMEOUT_CYCLES+2 -> frame_err, FSM=IDLE; following 75 decodes.
//     Repeat with resetn pulsed mid-frame: outputs=0, no frame_err until a frame arrives.
//  5. 3-clk low glitch on ps2_clk while IDLE -> no fall, no frame_err, no state change.
//  6. E0,75 x3, then E0,F0,75, then E0,75:
//     - Macro defined: key_valid count = 3 (make, break, make).
//     - Macro undefined: count = 5.

Source files
------------

// File: rtl/ps2_scancode_decoder_if.sv
// PS/2 keyboard decoder bus: raw PS/2 lines in, decoded key event out.
// key_valid is a one-clk strobe with no ready; the consumer must capture keycode/key_make/key_ext when it is high.
interface ps2_scancode_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;
  logic [1:0] dbg_state;

  modport master (
    output ps2_clk, ps2_dat,
    input  keycode, key_make, key_ext, key_valid, frame_err, dbg_state
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output keycode, key_make, key_ext, key_valid, frame_err, dbg_state
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode receiver/decoder with E0/F0 prefix handling.
// Optional typematic repeat suppression: define PS2_TYPEMATIC_FILTER_EN.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int FILTER_LEN     = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  ps2_scancode_decoder_if.slave  ps2_bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_filt_clk;
  logic [FW-1:0]          r_filt_cnt;
  logic [TW-1:0]          r_to_cnt;
  state_t                 r_state, w_state_next;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitcnt;
  logic                   r_par_ok;
  logic [7:0]             r_keycode;
  logic                   r_key_make, r_key_ext, r_key_valid, r_frame_err;
  logic                   r_ext_pend, r_brk_pend;
  logic                   w_clk_s, w_dat_s, w_filt_flip, w_fall, w_timeout;
  logic                   w_byte_done, w_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_bus.ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_bus.ps2_dat};
    end
  end

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample; a fall is that flip from 1.
  assign w_filt_flip = (w_clk_s != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_fall      = w_filt_flip && r_filt_clk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_filt_clk <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end

  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE || w_fall || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_byte_done  = 1'b0;
    w_err        = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_err        = 1'b1;
    end else if (w_fall) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_dat_s) w_state_next = S_DATA;
          else          w_err        = 1'b1;
        end
        S_DATA:   if (r_bitcnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        S_STOP: begin
          w_state_next = S_IDLE;
          if (w_dat_s && r_par_ok) w_byte_done = 1'b1;
          else                     w_err       = 1'b1;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par_ok <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: r_bitcnt <= '0;
        S_DATA: begin
          r_shift  <= {w_dat_s, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        S_PARITY: r_par_ok <= ^{r_shift, w_dat_s};
        default: ;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       r_last_vld;
  logic [8:0] r_last;
  logic       w_same, w_suppress;
  assign w_same     = r_last_vld && (r_last == {r_ext_pend, r_shift});
  assign w_suppress = w_same && !r_brk_pend;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_keycode   <= '0;
      r_key_make  <= 1'b0;
      r_key_ext   <= 1'b0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      r_last_vld  <= 1'b0;
      r_last      <= '0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= w_err;
      if (w_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        r_last_vld <= 1'b0;
`endif
      end else if (w_byte_done) begin
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else if (r_shift != 8'hE1) begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!w_suppress) begin
            r_keycode   <= r_shift;
            r_key_ext   <= r_ext_pend;
            r_key_make  <= ~r_brk_pend;
            r_key_valid <= 1'b1;
          end
          if (!r_brk_pend) begin
            r_last_vld <= 1'b1;
            r_last     <= {r_ext_pend, r_shift};
          end else if (w_same) begin
            r_last_vld <= 1'b0;
          end
`else
          r_keycode   <= r_shift;
          r_key_ext   <= r_ext_pend;
          r_key_make  <= ~r_brk_pend;
          r_key_valid <= 1'b1;
`endif
        end
      end
    end
  end

  assign ps2_bus.keycode   = r_keycode;
  assign ps2_bus.key_make  = r_key_make;
  assign ps2_bus.key_ext   = r_key_ext;
  assign ps2_bus.key_valid = r_key_valid;
  assign ps2_bus.frame_err = r_frame_err;
  assign ps2_bus.dbg_state = r_state;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: frames driven bit by bit, events captured on negedge.
module tb_ps2_scancode_decoder;
  localparam int HALF = 20;
  localparam int TO   = 50_000;

  logic       clk;
  logic       resetn;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         t_fall = 0;
  int         lat = 0;
  int         n_err = 0;
  int         n_both = 0;
  logic [9:0] ev_q[$];
  logic [9:0] ev;

  ps2_scancode_decoder_if bus();

  ps2_scancode_decoder #(
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ps2_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (bus.key_valid) begin
        ev_q.push_back({bus.key_ext, bus.key_make, bus.keycode});
        lat = cyc - t_fall;
      end
      if (bus.frame_err) n_err++;
      if (bus.key_valid && bus.frame_err) n_both++;
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_bit(input logic b, input bit last);
    bus.ps2_dat = b;
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b0;
    if (last) t_fall = cyc;
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_partial(input int n);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(i[0], 1'b0);
    repeat (HALF) @(posedge clk);
  endtask

  task automatic clear_mon();
    ev_q.delete();
    n_err = 0;
  endtask

  task automatic pop_ev(output logic [9:0] e);
    if (ev_q.size() > 0) e = ev_q.pop_front();
    else                 e = 'x;
  endtask

  task automatic chk_outputs(input string tag, input logic [9:0] exp_v);
    chk(tag, {22'd0, bus.key_ext, bus.key_make, bus.keycode}, {22'd0, exp_v});
  endtask

  initial begin
    resetn      = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_outputs("reset_outputs", 10'h000);
    chk("reset_valid", {31'd0, bus.key_valid}, 32'd0);
    chk("reset_err", {31'd0, bus.frame_err}, 32'd0);
    chk("reset_state", {30'd0, bus.dbg_state}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(posedge clk);

    // E0,75: extended make
    clear_mon();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    chk("t1_count", ev_q.size(), 32'd1);
    pop_ev(ev);
    chk("t1_event", {22'd0, ev}, {22'd0, 1'b1, 1'b1, 8'h75});
    chk("t1_err", n_err, 32'd0);
    chk("t1_latency_ok", {31'd0, (lat <= 12)}, 32'd1);
    chk_outputs("t1_hold", {1'b1, 1'b1, 8'h75});

    // E0,F0,75 then 1C
    clear_mon();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'h1C, 1'b0);
    chk("t2_count", ev_q.size(), 32'd2);
    pop_ev(ev);
    chk("t2_event1", {22'd0, ev}, {22'd0, 1'b1, 1'b0, 8'h75});
    pop_ev(ev);
    chk("t2_event2", {22'd0, ev}, {22'd0, 1'b0, 1'b1, 8'h1C});
    chk("t2_err", n_err, 32'd0);

    // E1 leaves the pending E0 in place
    clear_mon();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'h14, 1'b0);
    chk("t2b_count", ev_q.size(), 32'd1);
    pop_ev(ev);
    chk("t2b_event", {22'd0, ev}, {22'd0, 1'b1, 1'b1, 8'h14});

    // bad parity
    clear_mon();
    send_byte(8'h1C, 1'b1);
    chk("t3_err", n_err, 32'd1);
    chk("t3_count", ev_q.size(), 32'd0);
    chk_outputs("t3_hold", {1'b1, 1'b1, 8'h14});
    send_byte(8'h29, 1'b0);
    chk("t3_next_count", ev_q.size(), 32'd1);
    pop_ev(ev);
    chk("t3_next_event", {22'd0, ev}, {22'd0, 1'b0, 1'b1, 8'h29});
    chk("t3_err_total", n_err, 32'd1);

    // timeout mid-frame
    clear_mon();
    send_partial(5);
    chk("t4_state_data", {30'd0, bus.dbg_state}, 32'd1);
    repeat (TO + 100) @(posedge clk);
    chk("t4_timeout_err", n_err, 32'd1);
    chk("t4_state_idle", {30'd0, bus.dbg_state}, 32'd0);
    chk("t4_count", ev_q.size(), 32'd0);
    chk_outputs("t4_hold", {1'b0, 1'b1, 8'h29});
    send_byte(8'h75, 1'b0);
    pop_ev(ev);
    chk("t4_recover_event", {22'd0, ev}, {22'd0, 1'b0, 1'b1, 8'h75});

    // reset mid-frame
    clear_mon();
    send_partial(5);
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs("t4r_outputs", 10'h000);
    chk("t4r_state", {30'd0, bus.dbg_state}, 32'd0);
    resetn = 1'b1;
    repeat (200) @(posedge clk);
    chk("t4r_no_err", n_err, 32'd0);
    chk_outputs("t4r_still_zero", 10'h000);
    send_byte(8'h1C, 1'b0);
    pop_ev(ev);
    chk("t4r_event", {22'd0, ev}, {22'd0, 1'b0, 1'b1, 8'h1C});

    // short glitches on ps2_clk while idle
    clear_mon();
    bus.ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    chk("t5_err3", n_err, 32'd0);
    chk("t5_state3", {30'd0, bus.dbg_state}, 32'd0);
    bus.ps2_clk = 1'b0;
    repeat (7) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    chk("t5_err7", n_err, 32'd0);
    chk("t5_state7", {30'd0, bus.dbg_state}, 32'd0);
    chk("t5_count", ev_q.size(), 32'd0);

    // typematic repeats
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t6_count", ev_q.size(), 32'd3);
`else
    chk("t6_count", ev_q.size(), 32'd5);
`endif
    chk("t6_err", n_err, 32'd0);
    chk_outputs("t6_last", {1'b1, 1'b1, 8'h75});

    chk("valid_err_exclusive", n_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
